// File: rtl/imem_boot_pkg.sv
// ---------------------------------------------------------------------------
// imem_boot_pkg
// Shared definitions for the instruction-memory boot loader.
//   boot_state_e   : loader FSM states
//   BYTES_PER_WORD : stream bytes packed into one I_mem word
//   LEN_W          : width of the frame's word-count field
// ---------------------------------------------------------------------------
package imem_boot_pkg;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        LOAD,
        CSUM,
        DONE,
        ERROR
    } boot_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    // The loader takes stream bytes in every state except the two terminal ones.
    function automatic logic takes_bytes(boot_state_e st);
        return (st == HDR0) || (st == HDR1) || (st == LOAD) || (st == CSUM);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
// Byte stream into the boot loader (valid/ready handshake).
//   s_data  : stream byte
//   s_valid : s_data valid
//   s_ready : loader accepts byte this cycle; transfer = s_valid & s_ready
// master = stream source, slave = boot loader.
// ---------------------------------------------------------------------------
interface imem_boot_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/boot_word_packer.sv
// ---------------------------------------------------------------------------
// boot_word_packer
// Packs little-endian bytes into 32-bit words and emits a one-cycle
// word_valid pulse the cycle after the fourth byte of a word arrives.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : drop any partial word and restart at byte index 0
//   byte_valid  : byte_data is taken this cycle
//   byte_data   : incoming byte
//   last_byte   : current byte index is 3 (next taken byte completes a word)
//   word_valid  : registered pulse, word holds a completed word
//   word        : completed word, first byte in [7:0]
// ---------------------------------------------------------------------------
module boot_word_packer
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q;
    logic [23:0] low_q;   // bytes 0..2 of the word in progress

    assign last_byte = (idx_q == 2'(BYTES_PER_WORD - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            low_q      <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                idx_q <= '0;
                low_q <= '0;
            end else if (byte_valid) begin
                if (last_byte) begin
                    word       <= {byte_data, low_q};
                    word_valid <= 1'b1;
                    idx_q      <= '0;
                end else begin
                    low_q[idx_q*8 +: 8] <= byte_data;
                    idx_q               <= idx_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Runtime writer for the MIPS instruction memory. Receives a frame
//   LEN_LO, LEN_HI, 4*N data bytes, CSUM (XOR of all preceding bytes)
// writes the packed words to I_mem from word 0 upward and releases the
// core from reset only after the checksum has been verified.
//   clk, rst_n  : clock, asynchronous active-low reset
//   strm        : byte stream (slave side: s_data, s_valid in; s_ready out)
//   boot_req    : one-cycle restart request, honoured in DONE/ERROR only
//   imem_we     : I_mem write strobe, one cycle per word
//   imem_addr   : I_mem word address
//   imem_wdata  : I_mem write word
//   core_rst_n  : reset to the core; high only after a verified image
//   boot_done   : image loaded and verified
//   boot_err    : length or checksum error
// ---------------------------------------------------------------------------
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_boot_loader_if.slave   strm,
    input  logic                boot_req,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                core_rst_n,
    output logic                boot_done,
    output logic                boot_err
);

    // Largest legal word count: the whole memory.
    localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(1) << ADDR_W;

    boot_state_e state_q, state_d;

    logic [7:0]       len_lo_q;
    logic [LEN_W-1:0] len_q;
    logic [ADDR_W:0]  ptr_q;     // one extra bit so a full-memory image is countable
    logic [ADDR_W:0]  ptr_inc;
    logic [7:0]       xor_q;
    logic [LEN_W-1:0] len_hdr;
    logic             accept;
    logic             restart;
    logic             last_byte;
    logic             frame_end;
    logic             pack_clear;

    assign strm.s_ready = takes_bytes(state_q);
    assign accept       = strm.s_valid & strm.s_ready;
    assign restart      = boot_req & ((state_q == DONE) || (state_q == ERROR));
    assign len_hdr      = {strm.s_data, len_lo_q};
    assign ptr_inc      = ptr_q + (ADDR_W + 1)'(1);
    // Completing word ptr_q makes ptr_q+1 words; the frame ends when that equals N.
    assign frame_end    = (LEN_W'(ptr_inc) == len_q);
    assign pack_clear   = ((state_q == HDR1) && accept) || restart;

    boot_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pack_clear),
        .byte_valid (accept && (state_q == LOAD)),
        .byte_data  (strm.s_data),
        .last_byte  (last_byte),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HDR0;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HDR0: if (accept) state_d = HDR1;
            HDR1: begin
                if (accept) begin
                    if ({1'b0, len_hdr} > MAX_WORDS) state_d = ERROR;
                    else if (len_hdr == '0)          state_d = CSUM;
                    else                             state_d = LOAD;
                end
            end
            LOAD: if (accept && last_byte && frame_end) state_d = CSUM;
            CSUM: if (accept) state_d = (strm.s_data == xor_q) ? DONE : ERROR;
            DONE, ERROR: if (boot_req) state_d = HDR0;
            default: state_d = HDR0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo_q   <= '0;
            len_q      <= '0;
            ptr_q      <= '0;
            xor_q      <= '0;
            imem_addr  <= '0;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            boot_done  <= (state_d == DONE);
            boot_err   <= (state_d == ERROR);
            // Released one cycle after DONE is entered, dropped with the restart.
            core_rst_n <= (state_q == DONE) && (state_d == DONE);

            if (restart) begin
                len_lo_q  <= '0;
                len_q     <= '0;
                ptr_q     <= '0;
                xor_q     <= '0;
                imem_addr <= '0;
            end else if (accept) begin
                unique case (state_q)
                    HDR0: begin
                        len_lo_q <= strm.s_data;
                        xor_q    <= xor_q ^ strm.s_data;
                    end
                    HDR1: begin
                        len_q <= len_hdr;
                        ptr_q <= '0;
                        xor_q <= xor_q ^ strm.s_data;
                    end
                    LOAD: begin
                        xor_q <= xor_q ^ strm.s_data;
                        if (last_byte) begin
                            // Address lines up with the packer's word_valid pulse next cycle.
                            imem_addr <= ptr_q[ADDR_W-1:0];
                            ptr_q     <= ptr_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
// Directed frames against imem_boot_loader (ADDR_W = 8). A frame-level model
// derives the expected I_mem writes and final flags from the byte list; a
// monitor compares every write strobe and a few per-cycle invariants.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              boot_req = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              boot_done;
    logic              boot_err;

    imem_boot_loader_if bus ();

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .strm       (bus),
        .boot_req   (boot_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    logic [39:0]       act_log[$];
    logic [39:0]       ref_log[$];
    logic [31:0]       tb_mem[DEPTH];
    int                wr_count = 0;
    bit                gaps = 1'b0;
    logic              exp_done;
    logic              exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    task automatic make_frame(input wq_t words, input logic [7:0] flip, output bq_t f);
        logic [15:0] n;
        logic [7:0]  x;
        n = 16'(words.size());
        f = {};
        f.push_back(n[7:0]);
        f.push_back(n[15:8]);
        foreach (words[i])
            for (int b = 0; b < 4; b++)
                f.push_back(8'(words[i] >> (8 * b)));
        x = 8'h00;
        foreach (f[i]) x = x ^ f[i];
        f.push_back(x ^ flip);
    endtask

    // Queues every word the frame completes and sets the expected flags.
    task automatic model_frame(input bq_t f);
        int          n;
        logic [7:0]  x;
        n = int'({f[1], f[0]});
        if (n > DEPTH) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            if (2 + 4 * w + 3 < f.size()) begin
                exp_addr_q.push_back(ADDR_W'(w));
                exp_data_q.push_back({f[2+4*w+3], f[2+4*w+2], f[2+4*w+1], f[2+4*w]});
            end
        end
        x = 8'h00;
        for (int i = 0; i + 1 < f.size(); i++) x = x ^ f[i];
        exp_done = (f.size() == 4 * n + 3) && (f[f.size()-1] == x);
        exp_err  = (f.size() == 4 * n + 3) && (f[f.size()-1] != x);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_vs_flags", 32'(bus.s_ready), 32'(!(boot_done || boot_err)));
            check("core_run_without_done", 32'(core_rst_n & ~boot_done), 32'd0);
            if (imem_we) begin
                wr_count++;
                act_log.push_back({imem_addr, imem_wdata});
                tb_mem[imem_addr] = imem_wdata;
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", imem_addr, imem_wdata);
                end else begin
                    check("write_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
                    check("write_data", imem_wdata, exp_data_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        int k;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                bus.s_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        k = 0;
        while (!bus.s_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k == 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got s_ready=0 for 100 cycles, expected 1");
        end
        @(posedge clk);
    endtask

    task automatic send_bytes(input bq_t f);
        foreach (f[i]) send_byte(f[i]);
    endtask

    // Checks the cycle right after the last accepted byte, then the next one.
    task automatic finish_frame(input string name);
        @(negedge clk);
        bus.s_valid = 1'b0;
        check({name, "_done"}, 32'(boot_done), 32'(exp_done));
        check({name, "_err"}, 32'(boot_err), 32'(exp_err));
        check({name, "_core_rst_first"}, 32'(core_rst_n), 32'd0);
        @(negedge clk);
        check({name, "_core_rst"}, 32'(core_rst_n), 32'(exp_done));
        check({name, "_pending_writes"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic do_boot_req();
        @(negedge clk);
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
        check("restart_ready", 32'(bus.s_ready), 32'd1);
        check("restart_done", 32'(boot_done), 32'd0);
        check("restart_err", 32'(boot_err), 32'd0);
        check("restart_core_rst", 32'(core_rst_n), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected finish within 300000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t f, part;
        wq_t words;
        int  base;

        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_core_rst", 32'(core_rst_n), 32'd0);
        check("rst_done", 32'(boot_done), 32'd0);
        check("rst_err", 32'(boot_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.s_ready), 32'd1);

        // Two-word program, correct checksum
        words = '{32'h8C010000, 32'h00221820};
        make_frame(words, 8'h00, f);
        check("model_csum_A", 32'(f[10]), 32'h95);
        model_frame(f);
        check("model_done_A", 32'(exp_done), 32'd1);
        act_log.delete();
        send_bytes(f);
        finish_frame("frameA");
        check("frameA_nwrites", 32'(act_log.size()), 32'd2);
        check("frameA_w0", act_log[0][31:0], 32'h8C010000);
        check("frameA_w1", act_log[1][31:0], 32'h00221820);
        check("frameA_a1", 32'(act_log[1][39:32]), 32'd1);

        // Same frame, corrupted checksum
        do_boot_req();
        make_frame(words, 8'hFF, f);
        model_frame(f);
        check("model_err_B", 32'(exp_err), 32'd1);
        send_bytes(f);
        finish_frame("frameB");
        check("frameB_ready", 32'(bus.s_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("frameB_core_held", 32'(core_rst_n), 32'd0);
        do_boot_req();

        // Empty image
        base = wr_count;
        f = '{8'h00, 8'h00, 8'h00};
        model_frame(f);
        send_bytes(f);
        finish_frame("empty");
        check("empty_nwrites", 32'(wr_count - base), 32'd0);

        // Oversized length: 257 words
        do_boot_req();
        f = '{8'h01, 8'h01};
        model_frame(f);
        send_bytes(f);
        finish_frame("oversize");
        check("oversize_ready", 32'(bus.s_ready), 32'd0);

        // Four words, back-to-back then with random gaps
        do_boot_req();
        words = '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h0000FFFF};
        make_frame(words, 8'h00, f);
        model_frame(f);
        act_log.delete();
        send_bytes(f);
        finish_frame("n4_nogap");
        ref_log = act_log;
        do_boot_req();
        model_frame(f);
        act_log.delete();
        gaps = 1'b1;
        send_bytes(f);
        gaps = 1'b0;
        finish_frame("n4_gap");
        check("gap_nwrites", 32'(act_log.size()), 32'(ref_log.size()));
        for (int i = 0; i < 4 && i < act_log.size() && i < ref_log.size(); i++) begin
            check("gap_addr", 32'(act_log[i][39:32]), 32'(ref_log[i][39:32]));
            check("gap_data", act_log[i][31:0], ref_log[i][31:0]);
        end

        // Reset after six data bytes, then a fresh full frame
        do_boot_req();
        words = '{32'h11111111, 32'h22222222, 32'h33333333};
        make_frame(words, 8'h00, f);
        part = f[0:7];
        model_frame(part);
        send_bytes(part);
        @(negedge clk);
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_pending", 32'(exp_addr_q.size()), 32'd0);
        check("midrst_core_rst", 32'(core_rst_n), 32'd0);
        check("midrst_we", 32'(imem_we), 32'd0);
        check("midrst_done", 32'(boot_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        words = '{32'hCAFEF00D, 32'h0BADC0DE, 32'h13579BDF};
        make_frame(words, 8'h00, f);
        model_frame(f);
        act_log.delete();
        send_bytes(f);
        finish_frame("after_rst");
        check("after_rst_nwrites", 32'(act_log.size()), 32'd3);

        // Full memory image
        do_boot_req();
        words = {};
        for (int i = 0; i < DEPTH; i++) words.push_back((32'(i) * 32'h00010001) ^ 32'hA5000000);
        make_frame(words, 8'h00, f);
        model_frame(f);
        act_log.delete();
        send_bytes(f);
        finish_frame("full");
        check("full_nwrites", 32'(act_log.size()), 32'd256);
        check("full_last_addr", 32'(act_log[act_log.size()-1][39:32]), 32'hFF);
        base = wr_count;
        repeat (5) @(negedge clk);
        check("full_no_extra", 32'(wr_count - base), 32'd0);
        for (int i = 0; i < DEPTH; i++)
            check("full_mem", tb_mem[i], (32'(i) * 32'h00010001) ^ 32'hA5000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
